// File: rtl/seg_display_scanner.sv
// N-digit multiplexed seven-segment scanner with frame-aligned double buffering.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_display_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0] digit_en,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef logic [NUM_DIGITS-1:0][3:0] data_t;

  logic [PW-1:0]         presc;
  logic                  presc_tc;
  logic                  sel_last;
  logic                  wrap;
  logic [SW-1:0]         sel_nxt;

  data_t                 act_data;
  data_t                 pend_data;
  data_t                 nxt_data;
  logic [NUM_DIGITS-1:0] act_en;
  logic [NUM_DIGITS-1:0] pend_en;
  logic [NUM_DIGITS-1:0] nxt_en;
  logic                  pend_flag;

  logic                  lit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [6:0]            cathode_d;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_tc = (presc == PW'(SCAN_DIV - 1));
    sel_last = (digit_sel == SW'(NUM_DIGITS - 1));
    wrap     = presc_tc && sel_last;
    sel_nxt  = digit_sel;
    if (presc_tc) begin
      sel_nxt = sel_last ? '0 : digit_sel + SW'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0] act_mask;
  logic [NUM_DIGITS-1:0] pend_mask;
  logic [NUM_DIGITS-1:0] nxt_mask;
  logic [BW-1:0]         fcnt;
  logic [BW-1:0]         fcnt_nxt;
  logic                  phase;
  logic                  phase_nxt;
  logic                  fcnt_last;

  always_comb begin
    fcnt_last = (fcnt == BW'(BLINK_FRAMES - 1));
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    if (wrap) begin
      fcnt_nxt = fcnt_last ? '0 : fcnt + BW'(1);
      if (fcnt_last) begin
        phase_nxt = ~phase;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_FRAMES > 0);
`endif

  // New frame contents: a wrap-cycle load wins over anything pending.
  always_comb begin
    nxt_data = act_data;
    nxt_en   = act_en;
`ifdef SEG_BLINK_EN
    nxt_mask = act_mask;
`endif
    if (wrap) begin
      if (load) begin
        nxt_data = digit_data;
        nxt_en   = digit_en;
`ifdef SEG_BLINK_EN
        nxt_mask = blink_mask;
`endif
      end else if (pend_flag) begin
        nxt_data = pend_data;
        nxt_en   = pend_en;
`ifdef SEG_BLINK_EN
        nxt_mask = pend_mask;
`endif
      end
    end
  end

  always_comb begin
    lit = nxt_en[sel_nxt];
`ifdef SEG_BLINK_EN
    if (nxt_mask[sel_nxt] && !phase_nxt) begin
      lit = 1'b0;
    end
`endif
    onehot    = lit ? (NUM_DIGITS'(1) << sel_nxt) : '0;
    anode_d   = ANODE_ACTIVE_LOW ? ~onehot : onehot;
    cathode_d = lit ? seg7(nxt_data[sel_nxt]) : 7'h7F;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= '0;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
      act_data   <= '0;
      act_en     <= '0;
      pend_data  <= '0;
      pend_en    <= '0;
      pend_flag  <= 1'b0;
      anode      <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
      cathode    <= 7'h7F;
    end else begin
      presc      <= presc_tc ? '0 : presc + PW'(1);
      digit_sel  <= sel_nxt;
      frame_tick <= wrap;
      act_data   <= nxt_data;
      act_en     <= nxt_en;
      if (wrap) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_data <= digit_data;
        pend_en   <= digit_en;
        pend_flag <= 1'b1;
      end
      anode      <= anode_d;
      cathode    <= cathode_d;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      act_mask  <= '0;
      pend_mask <= '0;
      fcnt      <= '0;
      phase     <= 1'b1;
    end else begin
      act_mask <= nxt_mask;
      fcnt     <= fcnt_nxt;
      phase    <= phase_nxt;
      if (!wrap && load) begin
        pend_mask <= blink_mask;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner: frame-level reference model,
// expectations queued at drive time and checked by an independent monitor.
module tb_seg_display_scanner;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;
  localparam int FR = S * N;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  always #5 clock = ~clock;

  seg_display_scanner #(
    .NUM_DIGITS(N),
    .SCAN_DIV(S),
    .ANODE_ACTIVE_LOW(1'b1),
    .BLINK_FRAMES(BF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .digit_data(digit_data),
    .digit_en(digit_en),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .anode(anode),
    .cathode(cathode),
    .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] ca;
    logic       tk;
  } exp_t;

  logic [6:0] lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   started = 1'b0;

  // Reference state: cycles since reset, committed frame and pending frame.
  int          n = 0;
  bit          pflag = 1'b0;
  logic [15:0] a_d = '0, p_d = '0;
  logic [3:0]  a_e = '0, p_e = '0, a_m = '0, p_m = '0;

  task automatic drive(input bit r, input bit l, input logic [15:0] d,
                       input logic [3:0] e, input logic [3:0] m);
    exp_t x;
    int   dg;
    bit   wr, vis, lit;
    logic [3:0] nib;
    @(negedge clock);
    reset = r; load = l; digit_data = d; digit_en = e; blink_mask = m;
    if (r) begin
      n = 0; pflag = 1'b0;
      a_d = '0; a_e = '0; a_m = '0;
      p_d = '0; p_e = '0; p_m = '0;
      x.sel = 2'd0; x.an = 4'hF; x.ca = 7'h7F; x.tk = 1'b0;
    end else begin
      n++;
      wr = (n % FR) == 0;
      if (wr) begin
        if (l) begin
          a_d = d; a_e = e; a_m = m;
        end else if (pflag) begin
          a_d = p_d; a_e = p_e; a_m = p_m;
        end
        pflag = 1'b0;
      end else if (l) begin
        p_d = d; p_e = e; p_m = m; pflag = 1'b1;
      end
      dg = (n / S) % N;
`ifdef SEG_BLINK_EN
      vis = (((n / FR) / BF) % 2) == 0;
`else
      vis = 1'b1;
`endif
      lit = a_e[dg] && !(a_m[dg] && !vis);
      nib = a_d[dg*4 +: 4];
      x.sel = 2'(dg);
      x.an  = lit ? ~(4'b0001 << dg) : 4'hF;
      x.ca  = lit ? lut[nib] : 7'h7F;
      x.tk  = wr;
    end
    q.push_back(x);
    started = 1'b1;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++)
      drive(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_digit(input int dg);
    for (int i = 0; i < FR && ((n + 1) / S) % N != dg; i++)
      idle(1);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (started) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          x = q.pop_front();
          if (digit_sel !== x.sel || anode !== x.an ||
              cathode !== x.ca || frame_tick !== x.tk) begin
            mismatched++;
            $display("FAIL scan t=%0t sel=%0d/%0d anode=%b/%b cathode=%b/%b tick=%b/%b",
                     $time, digit_sel, x.sel, anode, x.an, cathode, x.ca,
                     frame_tick, x.tk);
          end
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; load = 1'b0;
    digit_data = '0; digit_en = '0; blink_mask = '0;
    drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 16'h1A2F, 4'hF, 4'h0);
    idle(3 * FR);
    wait_digit(1);
    drive(1'b0, 1'b1, 16'h8888, 4'hF, 4'h0);
    idle(2 * FR);
    drive(1'b0, 1'b1, 16'h1A2F, 4'b1011, 4'h0);
    idle(2 * FR);
    drive(1'b0, 1'b1, 16'h5555, 4'hF, 4'h0);
    wait_digit(2);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(2 * FR);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 16'h3C4E, 4'hF, 4'b0001);
    idle(8 * FR);
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0,
            16'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
            4'($urandom));
    end
    @(posedge clock);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
